// File: rtl/alu_defs.sv
// Shared definitions for the ALU arbiter: opcodes, FSM encoding, default width.
package alu_defs;

    localparam int ALU_WIDTH = 32;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_SLT  = 3'd2;
    localparam logic [2:0] ALU_XOR  = 3'd3;
    localparam logic [2:0] ALU_AND  = 3'd4;
    localparam logic [2:0] ALU_NAND = 3'd5;
    localparam logic [2:0] ALU_NOR  = 3'd6;
    localparam logic [2:0] ALU_OR   = 3'd7;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-input round-robin grant logic with the last-grant history flop.
module rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic update,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    always_comb begin
        grant0 = req0 & (~req1 | last_grant);
        grant1 = req1 & ~grant0;
    end

    // Reset to 1 so requester 0 wins the first contested grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= 1'b1;
        else if (update)
            last_grant <= grant1;
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters; optional per-requester
// response counters under ALU_ARBITER_STATS_EN.
module alu_arbiter
    import alu_defs::*;
#(
    parameter int WIDTH         = ALU_WIDTH,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carryout,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_control,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carryout,
    input  logic             alu_overflow,
    input  logic             alu_zero
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [15:0]      ops0_count,
    output logic [15:0]      ops1_count
`endif
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..15");
    end

    logic [1:0] state;
    logic [3:0] cnt;
    logic       owner;
    logic       grant0;
    logic       grant1;
    logic       idle;
    logic       accept;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .update (accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    always_comb begin
        idle       = (state == IDLE);
        req0_ready = idle & grant0;
        req1_ready = idle & grant1;
        accept     = req0_ready | req1_ready;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            owner        <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_control  <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_carryout <= 1'b0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a       <= grant1 ? req1_a  : req0_a;
                        alu_b       <= grant1 ? req1_b  : req0_b;
                        alu_control <= grant1 ? req1_op : req0_op;
                        owner       <= grant1;
                        cnt         <= 4'(SETTLE_CYCLES - 1);
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rsp_id       <= owner;
                        rsp_result   <= alu_out;
                        rsp_carryout <= alu_carryout;
                        rsp_overflow <= alu_overflow;
                        rsp_zero     <= alu_zero;
                        rsp_valid    <= 1'b1;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARBITER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ops0_count <= '0;
            ops1_count <= '0;
        end else if (rsp_valid && rsp_ready) begin
            if (!rsp_id && ops0_count != '1)
                ops0_count <= ops0_count + 16'd1;
            if (rsp_id && ops1_count != '1)
                ops1_count <= ops1_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a delayed behavioural ALU attached.
module tb_alu_arbiter;
    import alu_defs::*;

    localparam int W   = 32;
    localparam int S   = 4;
    localparam int DLY = S - 1;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
    } req_t;

    typedef struct {
        logic         id;
        req_t         rq;
        logic [W+2:0] res;
        int           due;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   rv;
    req_t         rd [2];
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_carryout, rsp_overflow, rsp_zero;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic [2:0]   alu_control;
    logic         alu_carryout, alu_overflow, alu_zero;
`ifdef ALU_ARBITER_STATS_EN
    logic [15:0]  ops0_count, ops1_count;
    int           m_cnt0 = 0, m_cnt1 = 0;
`endif

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           rdy_mode = 0;
    req_t         dq0 [$];
    req_t         dq1 [$];
    exp_t         exp_q [$];
    logic         grant_log [$];
    logic [W-1:0] res0_log [$];
    logic         hs_seen [2];
    logic         mdl_last = 1'b1;
    logic         mdl_busy = 1'b0;
    logic         m_exp0, m_exp1;
    logic         rsp_prev = 1'b0;
    logic [W+2:0] last_res;
    logic         last_id;
    logic [W+2:0] alu_pipe [DLY];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .reset        (reset),
        .req0_valid   (rv[0]),
        .req0_ready   (req0_ready),
        .req0_a       (rd[0].a),
        .req0_b       (rd[0].b),
        .req0_op      (rd[0].op),
        .req1_valid   (rv[1]),
        .req1_ready   (req1_ready),
        .req1_a       (rd[1].a),
        .req1_b       (rd[1].b),
        .req1_op      (rd[1].op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_carryout (rsp_carryout),
        .rsp_overflow (rsp_overflow),
        .rsp_zero     (rsp_zero),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_control  (alu_control),
        .alu_out      (alu_out),
        .alu_carryout (alu_carryout),
        .alu_overflow (alu_overflow),
        .alu_zero     (alu_zero)
`ifdef ALU_ARBITER_STATS_EN
        ,
        .ops0_count   (ops0_count),
        .ops1_count   (ops1_count)
`endif
    );

    // Returns {carry, overflow, zero, result}.
    function automatic logic [W+2:0] ref_alu(logic [W-1:0] a, logic [W-1:0] b, logic [2:0] op);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         c, v;
        c = 1'b0;
        v = 1'b0;
        s = '0;
        case (op)
            ALU_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                s = {1'b0, a} + {1'b0, ~b} + 1;
                r = s[W-1:0];
                c = s[W];
                v = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            ALU_SLT:  r = ($signed(a) < $signed(b)) ? 1 : 0;
            ALU_XOR:  r = a ^ b;
            ALU_AND:  r = a & b;
            ALU_NAND: r = ~(a & b);
            ALU_NOR:  r = ~(a | b);
            default:  r = a | b;
        endcase
        return {c, v, (r == '0), r};
    endfunction

    // The ALU settles DLY clocks after its inputs change; an early capture sees stale data.
    always @(posedge clk) begin
        alu_pipe[0] <= ref_alu(alu_a, alu_b, alu_control);
        for (int i = 1; i < DLY; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign {alu_carryout, alu_overflow, alu_zero, alu_out} = alu_pipe[DLY-1];

    task automatic check(string nm, logic [W+2:0] act, logic [W+2:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_bound(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.op = 3'($urandom_range(7, 0));
        r.a  = $urandom;
        r.b  = ($urandom_range(3, 0) == 0) ? r.a : $urandom;
        return r;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (reset) begin
            rsp_prev = 1'b0;
        end else begin
            if (mdl_busy) begin
                m_exp0 = 1'b0;
                m_exp1 = 1'b0;
            end else begin
                m_exp0 = rv[0] && (!rv[1] || mdl_last);
                m_exp1 = rv[1] && !m_exp0;
            end
            check("req0_ready", req0_ready, m_exp0);
            check("req1_ready", req1_ready, m_exp1);

            if (exp_q.size() > 0) begin
                check("alu_a", alu_a, exp_q[0].rq.a);
                check("alu_b", alu_b, exp_q[0].rq.b);
                check("alu_control", alu_control, exp_q[0].rq.op);
                if (!rsp_valid && cyc == exp_q[0].due)
                    check("rsp_missing", rsp_valid, 1);
            end
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    if (!rsp_prev) check("rsp_latency", cyc, exp_q[0].due);
                    check("rsp_id", rsp_id, exp_q[0].id);
                    check("rsp_result", rsp_result, exp_q[0].res[W-1:0]);
                    check("rsp_flags", {rsp_carryout, rsp_overflow, rsp_zero}, exp_q[0].res[W+2:W]);
                    if (rsp_ready) begin
                        last_res = {rsp_carryout, rsp_overflow, rsp_zero, rsp_result};
                        last_id  = rsp_id;
                        if (!rsp_id) res0_log.push_back(rsp_result);
`ifdef ALU_ARBITER_STATS_EN
                        if (exp_q[0].id) m_cnt1++; else m_cnt0++;
`endif
                        void'(exp_q.pop_front());
                        mdl_busy = 1'b0;
                    end
                end
            end
            rsp_prev = rsp_valid;

            if ((rv[0] && req0_ready) || (rv[1] && req1_ready)) begin
                exp_t e;
                e.id  = rv[1] && req1_ready;
                e.rq  = rd[e.id];
                e.res = ref_alu(e.rq.a, e.rq.b, e.rq.op);
                e.due = cyc + 1 + S;
                exp_q.push_back(e);
                grant_log.push_back(e.id);
                hs_seen[e.id] = 1'b1;
                mdl_last = e.id;
                mdl_busy = 1'b1;
            end
        end
    end

    // Requester and consumer drivers
    initial begin
        rv = '0;
        rd[0] = '0;
        rd[1] = '0;
        rsp_ready = 1'b1;
        hs_seen[0] = 1'b0;
        hs_seen[1] = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hs_seen[0]) begin
                hs_seen[0] = 1'b0;
                rv[0] = 1'b0;
                if (dq0.size() > 0) void'(dq0.pop_front());
            end
            if (hs_seen[1]) begin
                hs_seen[1] = 1'b0;
                rv[1] = 1'b0;
                if (dq1.size() > 0) void'(dq1.pop_front());
            end
            rv[0] = dq0.size() > 0 && (rv[0] || rdy_mode != 1 || $urandom_range(1, 0) == 1);
            rv[1] = dq1.size() > 0 && (rv[1] || rdy_mode != 1 || $urandom_range(1, 0) == 1);
            if (rv[0]) rd[0] = dq0[0];
            if (rv[1]) rd[1] = dq1[0];
            rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 2) ? 1'b0 : 1'($urandom_range(1, 0));
        end
    end

    task automatic drain(int bound);
        int n = 0;
        while ((dq0.size() > 0 || dq1.size() > 0 || exp_q.size() > 0 || mdl_busy || rv != 0) && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (n >= bound) fail_bound("drain");
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_rsp_flags"}, {rsp_carryout, rsp_overflow, rsp_zero}, 0);
        check({tag, "_alu_ab"}, {alu_a, alu_b}, 0);
        check({tag, "_alu_control"}, alu_control, 0);
        check({tag, "_ready"}, {req0_ready, req1_ready}, 0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_outputs_zero("reset");
        @(posedge clk);
        #3 reset = 1'b0;

        dq0.push_back('{a: 32'd5, b: 32'd7, op: ALU_ADD});
        drain(200);
        check("add_result", last_res[W-1:0], 32'd12);
        check("add_id", last_id, 0);
        check("add_zero_ovf", last_res[W+1:W], 2'b00);

        dq0.push_back('{a: 32'h7FFF_FFFF, b: 32'd1, op: ALU_ADD});
        drain(200);
        check("ovf_result", last_res[W-1:0], 32'h8000_0000);
        check("ovf_flag", last_res[W+1], 1);

        dq1.push_back('{a: 32'd3, b: 32'd3, op: ALU_SUB});
        drain(200);
        check("sub_result", last_res[W-1:0], 0);
        check("sub_zero", last_res[W], 1);
        check("sub_id", last_id, 1);

        grant_log.delete();
        res0_log.delete();
        for (int i = 0; i < 4; i++) begin
            dq0.push_back('{a: 32'hF0F0, b: 32'hFF00, op: ALU_AND});
            dq1.push_back('{a: $urandom, b: $urandom, op: ALU_OR});
        end
        drain(400);
        check("alt_count", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size(); i++) check("alt_order", grant_log[i], i % 2);
        check("alt_res0_count", res0_log.size(), 4);
        for (int i = 0; i < res0_log.size(); i++) check("alt_res0", res0_log[i], 32'hF000);

        rdy_mode = 2;
        dq0.push_back('{a: $urandom, b: $urandom, op: ALU_XOR});
        dq1.push_back('{a: $urandom, b: $urandom, op: ALU_NOR});
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk); n++; end
        if (n >= 100) fail_bound("bp_rsp_valid");
        repeat (10) @(posedge clk);
        rdy_mode = 0;
        drain(200);

        dq0.push_back('{a: $urandom, b: $urandom, op: ALU_ADD});
        n = 0;
        while (!mdl_busy && n < 100) begin @(posedge clk); n++; end
        if (n >= 100) fail_bound("rst_busy");
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        rv = '0;
        dq0.delete();
        dq1.delete();
        #1;
        check_outputs_zero("midreset");
        exp_q.delete();
        hs_seen[0] = 1'b0;
        hs_seen[1] = 1'b0;
        mdl_busy = 1'b0;
        mdl_last = 1'b1;
`ifdef ALU_ARBITER_STATS_EN
        m_cnt0 = 0;
        m_cnt1 = 0;
`endif
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        grant_log.delete();
        dq1.push_back('{a: $urandom, b: $urandom, op: ALU_SLT});
        dq0.push_back('{a: $urandom, b: $urandom, op: ALU_NAND});
        drain(200);
        check("post_reset_count", grant_log.size(), 2);
        if (grant_log.size() > 0) check("post_reset_grant", grant_log[0], 0);

        rdy_mode = 1;
        for (int i = 0; i < 30; i++) begin
            dq0.push_back(rand_req());
            dq1.push_back(rand_req());
        end
        drain(5000);
        rdy_mode = 0;
        @(negedge clk);

`ifdef ALU_ARBITER_STATS_EN
        check("ops0_count", ops0_count, m_cnt0);
        check("ops1_count", ops1_count, m_cnt1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequencer and arbiter that shares one ALU32Bit instance between two requesters.
- Accepts operand/opcode requests over valid/ready handshakes, using round-robin arbitration between requesters.
- Drives the shared ALU from registers, waits a fixed number of settle cycles to cover the gate-level propagation delays, captures result and flags, then returns them on a single tagged response channel.
- Sits between instruction/test drivers and the combinational ALU32Bit datapath.

Parameters:
- WIDTH, 32: operand/result width; must match the ALU.
- SETTLE_CYCLES, 4: clock edges between driving the ALU and capturing its outputs; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  3  requester 0 ALU control code.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer takes response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH  captured ALU out.
- rsp_carryout, rsp_overflow, rsp_zero  out  1 each  captured ALU flags.
- alu_a, alu_b  out  WIDTH  to ALU a/b.
- alu_control  out  3  to ALU control.
- alu_out  in  WIDTH  from ALU.
- alu_carryout, alu_overflow, alu_zero  in  1 each  from ALU.

Behaviour:
- Reset (async, active-high):
  - state=IDLE, last_grant=1 so requester 0 wins first.
  - Counter=0.
  - All alu_* and rsp_* registers are 0; rsp_valid=0.
  - A reset mid-transaction drops that transaction silently.
- FSM states are IDLE, WAIT and RESP.
- Grant logic (combinational, evaluated only in IDLE):
  - grant0 = req0_valid & (!req1_valid | last_grant==1).
  - grant1 = req1_valid & !grant0.
  - reqN_ready = (state==IDLE) & grantN.
  - Both ready signals are 0 outside IDLE.
- IDLE, at an edge where a handshake completes:
  - Latch the winner's a/b/op into alu_a/alu_b/alu_control.
  - Record its id; last_grant=id.
  - counter=SETTLE_CYCLES-1; go to WAIT.
  - With no valid request, stay in IDLE and hold the alu_* registers.
- WAIT, each edge:
  - If counter==0: capture alu_out and flags into the rsp_* registers, set rsp_valid=1, go to RESP.
  - Otherwise decrement the counter.
  - The alu_* registers stay stable throughout WAIT.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On an edge with rsp_ready=1: rsp_valid=0, go to IDLE.
  - No new request is accepted in the same cycle.
- Latency: handshake at edge k; response registered at edge k+SETTLE_CYCLES; rsp_valid visible from then.
- Throughput: one operation per SETTLE_CYCLES+2 cycles minimum.
- Arbitration cases:
  - Simultaneous requests alternate strictly.
  - A lone requester is granted every time regardless of last_grant.
- req*_op is passed through unmodified. Codes are 0 ADD, 1 SUB, 2 SLT, 3 XOR, 4 AND, 5 NAND, 6 NOR, 7 OR.
- Requesters must hold a/b/op stable while valid && !ready.

Optional Feature:
- Macro: ALU_ARBITER_STATS_EN.
- When defined:
  - Adds output ports ops0_count and ops1_count, 16 bits each.
  - Each counter increments on a response handshake (rsp_valid & rsp_ready) with matching rsp_id.
  - Counters saturate at 0xFFFF and reset to 0.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package alu_defs holds:
  - The opcode constants ALU_ADD..ALU_OR (3-bit).
  - The FSM state encoding: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - The default WIDTH.
- One natural sub-module: rr_arbiter2, the two-input round-robin grant logic plus the last_grant flop.

Test Plan:
- req0 ADD a=5, b=7, SETTLE_CYCLES=4 -> req0_ready pulses one cycle; rsp_valid rises 4 edges later with rsp_result=12, rsp_id=0, zero=0, overflow=0.
- req1 SUB a=3, b=3 -> rsp_result=0, rsp_zero=1, rsp_id=1.
- req0 ADD a=0x7FFFFFFF, b=1 -> rsp_result=0x80000000, rsp_overflow=1.
- Both valid continuously, 4 ops each (AND 0xF0F0/0xFF00 on req0, OR on req1) -> grants in order 0,1,0,1,0,1,0,1; req0 results all 0xF000.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_* stable; both req*_ready stay 0; after rsp_ready=1, back to IDLE the next edge.
- Reset asserted during WAIT -> all outputs 0 immediately (async); no response issued; the next request is granted to req0.
